simon_multi: RTL and testbench

- Parametrised next-generation Simon Says core. Supports 2..8 button/LED channels, a configurable maximum sequence length, and per-level tempo speed-up. Adds a win state and an optional input timeout.
- Sits between the button synchroniser/debouncer and the existing sound generator and score display.
- Outputs a tone frequency code and a binary score rather than driving those blocks directly.

---
 rtl/simon_multi.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_simon_multi.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/simon_multi.sv
// simon_multi: parametrised Simon Says game core.
//
// Plays a growing pseudo-random sequence on NUM_CH LEDs with matching tones. The player must
// repeat it on the buttons. Winning MAX_LEN levels enters WIN. A wrong press enters GAME_OVER.
//
// Optional feature macro: SIMON_TIMEOUT_EN. When it is defined, inactivity in USER_WAIT for
// TIMEOUT_MS ms ends the game. When it is undefined, USER_WAIT waits forever.
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   ticks_per_milli  clk cycles per millisecond (static during play)
//   btn              debounced buttons, active-high; only one-hot patterns count as a press
//   led              channel LEDs, active-high
//   freq             tone frequency code for the sound generator, 0 = silent
//   score            completed levels, binary
//   game_over        high while in GAME_OVER
//   game_won         high while in WIN
module simon_multi #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned MAX_LEN    = 99,
    parameter int unsigned ON_MS      = 300,
    parameter int unsigned GAP_MS     = 100,
    parameter int unsigned SPEEDUP_MS = 10,
    parameter int unsigned MIN_ON_MS  = 120,
    parameter int unsigned BASE_FREQ  = 196,
    parameter int unsigned STEP_FREQ  = 96,
    parameter int unsigned TIMEOUT_MS = 3000,
    localparam int unsigned CH_BITS   = $clog2(NUM_CH),
    localparam int unsigned LEN_BITS  = $clog2(MAX_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         ticks_per_milli,
    input  logic [NUM_CH-1:0]   btn,
    output logic [NUM_CH-1:0]   led,
    output logic [9:0]          freq,
    output logic [LEN_BITS-1:0] score,
    output logic                game_over,
    output logic                game_won
);

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StInit      = 3'd1;
    localparam logic [2:0] StPlay      = 3'd2;
    localparam logic [2:0] StUserWait  = 3'd3;
    localparam logic [2:0] StUserPress = 3'd4;
    localparam logic [2:0] StLevelUp   = 3'd5;
    localparam logic [2:0] StGameOver  = 3'd6;
    localparam logic [2:0] StWin       = 3'd7;

    logic [2:0]          state_q, state_d;
    logic [15:0]         tick_q, tick_d;
    logic [11:0]         ms_q, ms_d;
    logic                done_q, done_d;      // state-specific minimum time has elapsed
    logic [15:0]         lfsr_q, lfsr_d;
    logic [15:0]         seed_q, seed_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic [LEN_BITS-1:0] idx_q, idx_d;
    logic [LEN_BITS-1:0] score_q, score_d;
    logic [CH_BITS-1:0]  pos_q, pos_d;        // chase position in IDLE and WIN
    logic                play_on_q, play_on_d;
    logic [CH_BITS-1:0]  user_ch_q, user_ch_d;
    logic                armed_q, armed_d;    // btn seen at 0 since entering USER_WAIT
    logic [NUM_CH-1:0]   led_q, led_d;
    logic [9:0]          freq_q, freq_d;
    logic                game_over_q, game_over_d;
    logic                game_won_q, game_won_d;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    function automatic logic [CH_BITS-1:0] fold_ch(input logic [15:0] l);
        int unsigned raw;
        raw = 32'(l[CH_BITS-1:0]);
        if (raw >= NUM_CH) raw = raw - NUM_CH;
        return CH_BITS'(raw);
    endfunction

    function automatic logic [9:0] tone(input logic [CH_BITS-1:0] ch);
        int unsigned t;
        t = BASE_FREQ + 32'(ch) * STEP_FREQ;
        return t[9:0];
    endfunction

    // True on the tick that completes n ms in the current state or phase.
    function automatic logic hit(input logic tk, input logic [11:0] ms, input int unsigned n);
        return tk && (n != 0) && (32'(ms) == n - 1);
    endfunction

    logic               ms_tick;
    logic               press;
    logic [CH_BITS-1:0] press_ch;
    logic [CH_BITS-1:0] cur_ch;
    logic [CH_BITS-1:0] pos_next;
    int unsigned        on_ms;
    int unsigned        done_thr;
    logic               chg;

    always_comb begin
        int unsigned red;
        ms_tick  = (tick_q == ticks_per_milli - 16'd1);
        press    = $onehot(btn);
        press_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (btn[i]) press_ch = CH_BITS'(i);
        end
        cur_ch   = fold_ch(lfsr_q);
        pos_next = (32'(pos_q) == NUM_CH - 1) ? '0 : pos_q + CH_BITS'(1);
        // Saturating speed-up, then clamp to the floor.
        red   = 32'(score_q) * SPEEDUP_MS;
        on_ms = (ON_MS > red) ? ON_MS - red : 0;
        if (on_ms < MIN_ON_MS) on_ms = MIN_ON_MS;
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q + 16'd1;
        ms_d      = ms_q;
        lfsr_d    = lfsr_q;
        seed_d    = seed_q;
        len_d     = len_q;
        idx_d     = idx_q;
        score_d   = score_q;
        pos_d     = pos_q;
        play_on_d = play_on_q;
        user_ch_d = user_ch_q;
        armed_d   = armed_q;
        chg       = 1'b0;

        if (ms_tick) begin
            tick_d = '0;
            ms_d   = ms_q + 12'd1;
        end

        case (state_q)
            StUserPress:           done_thr = 50;
            StGameOver, StWin:     done_thr = 1000;
            default:               done_thr = 0;
        endcase
        done_d = done_q | hit(ms_tick, ms_q, done_thr);

        case (state_q)
            StIdle: begin
                lfsr_d = lfsr_step(lfsr_q);
                if (ms_tick && ms_q[7:0] == 8'hFF) pos_d = pos_next;
                if (press) begin
                    state_d = StInit;
                    chg     = 1'b1;
                end
            end
            StInit: begin
                if (hit(ms_tick, ms_q, 500)) begin
                    seed_d    = lfsr_q;
                    score_d   = '0;
                    len_d     = LEN_BITS'(1);
                    idx_d     = '0;
                    play_on_d = 1'b1;
                    state_d   = StPlay;
                    chg       = 1'b1;
                end
            end
            StPlay: begin
                if (play_on_q) begin
                    if (hit(ms_tick, ms_q, on_ms)) begin
                        play_on_d = 1'b0;
                        chg       = 1'b1;
                    end
                end else if (hit(ms_tick, ms_q, GAP_MS)) begin
                    chg = 1'b1;
                    if (idx_q == len_q - LEN_BITS'(1)) begin
                        idx_d   = '0;
                        lfsr_d  = seed_q;
                        armed_d = 1'b0;
                        state_d = StUserWait;
                    end else begin
                        idx_d     = idx_q + LEN_BITS'(1);
                        lfsr_d    = lfsr_step(lfsr_step(lfsr_q));
                        play_on_d = 1'b1;
                    end
                end
            end
            StUserWait: begin
                if (btn == '0) armed_d = 1'b1;
                if (press && armed_q) begin
                    user_ch_d = press_ch;
                    state_d   = StUserPress;
                    chg       = 1'b1;
                end
`ifdef SIMON_TIMEOUT_EN
                else if (hit(ms_tick, ms_q, TIMEOUT_MS)) begin
                    state_d = StGameOver;
                    chg     = 1'b1;
                end
`endif
            end
            StUserPress: begin
                if (btn == '0 && done_q) begin
                    chg = 1'b1;
                    if (user_ch_q != cur_ch) begin
                        state_d = StGameOver;
                    end else if (idx_q == len_q - LEN_BITS'(1)) begin
                        score_d = score_q + LEN_BITS'(1);
                        if (len_q == LEN_BITS'(MAX_LEN)) begin
                            state_d = StWin;
                        end else begin
                            len_d   = len_q + LEN_BITS'(1);
                            state_d = StLevelUp;
                        end
                    end else begin
                        idx_d   = idx_q + LEN_BITS'(1);
                        lfsr_d  = lfsr_step(lfsr_step(lfsr_q));
                        armed_d = 1'b0;
                        state_d = StUserWait;
                    end
                end
            end
            StLevelUp: begin
                if (hit(ms_tick, ms_q, 600)) begin
                    idx_d     = '0;
                    lfsr_d    = seed_q;
                    play_on_d = 1'b1;
                    state_d   = StPlay;
                    chg       = 1'b1;
                end
            end
            StGameOver, StWin: begin
                // Free-run so the next game gets a fresh seed.
                lfsr_d = lfsr_step(lfsr_q);
                if (state_q == StWin && ms_tick && ms_q[6:0] == 7'h7F) pos_d = pos_next;
                if (press && done_q) begin
                    state_d = StInit;
                    chg     = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (chg) begin
            tick_d = '0;
            ms_d   = '0;
            done_d = 1'b0;
            pos_d  = '0;
        end
    end

    // Outputs are registered so they read zero throughout reset.
    always_comb begin
        led_d       = '0;
        freq_d      = '0;
        game_over_d = (state_q == StGameOver);
        game_won_d  = (state_q == StWin);
        case (state_q)
            StIdle, StWin: led_d = NUM_CH'(1) << pos_q;
            StPlay: begin
                if (play_on_q) begin
                    led_d  = NUM_CH'(1) << cur_ch;
                    freq_d = tone(cur_ch);
                end
            end
            StUserPress: begin
                led_d  = NUM_CH'(1) << user_ch_q;
                freq_d = tone(user_ch_q);
            end
            StGameOver: begin
                led_d  = ms_q[7] ? '0 : '1;
                freq_d = done_q ? 10'd0 : 10'(BASE_FREQ / 2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tick_q      <= '0;
            ms_q        <= '0;
            done_q      <= 1'b0;
            lfsr_q      <= 16'hACE1;
            seed_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            score_q     <= '0;
            pos_q       <= '0;
            play_on_q   <= 1'b0;
            user_ch_q   <= '0;
            armed_q     <= 1'b0;
            led_q       <= '0;
            freq_q      <= '0;
            game_over_q <= 1'b0;
            game_won_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            ms_q        <= ms_d;
            done_q      <= done_d;
            lfsr_q      <= lfsr_d;
            seed_q      <= seed_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            score_q     <= score_d;
            pos_q       <= pos_d;
            play_on_q   <= play_on_d;
            user_ch_q   <= user_ch_d;
            armed_q     <= armed_d;
            led_q       <= led_d;
            freq_q      <= freq_d;
            game_over_q <= game_over_d;
            game_won_q  <= game_won_d;
        end
    end

    assign led       = led_q;
    assign freq      = freq_q;
    assign score     = score_q;
    assign game_over = game_over_q;
    assign game_won  = game_won_q;

endmodule

// File: tb/tb_simon_multi.sv
// Directed bench for simon_multi with NUM_CH=4, MAX_LEN=3, TIMEOUT_MS=50, ticks_per_milli=1.
module tb_simon_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] tpm = 16'd1;
    logic [3:0]  btn = 4'd0;
    logic [3:0]  led;
    logic [9:0]  freq;
    logic [1:0]  score;
    logic        game_over;
    logic        game_won;

    int n_vec = 0;
    int n_err = 0;
    int seq[8];

    simon_multi #(
        .NUM_CH    (4),
        .MAX_LEN   (3),
        .TIMEOUT_MS(50)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ticks_per_milli(tpm),
        .btn            (btn),
        .led            (led),
        .freq           (freq),
        .score          (score),
        .game_over      (game_over),
        .game_won       (game_won)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    // Observes one PLAY pass: dark lead-in, per-element on-time, tone, channel and gap.
    task automatic play_pass(input int len, input int pre_dark, input int on_exp,
                             input bit use_model, input logic [15:0] seed, input int replay);
        logic [15:0] m;
        logic [3:0]  pat;
        int          ch, dark, on, guard;
        m = seed;
        for (int i = 0; i < len; i++) begin
            guard = 0;
            while (led != 4'd0 && guard < 2000) begin
                cyc(1);
                guard++;
            end
            dark = 0;
            while (led == 4'd0 && dark < 5000) begin
                cyc(1);
                dark++;
            end
            if (i == 0) begin
                if (pre_dark >= 0) check("lead_dark", dark, pre_dark);
            end else begin
                check("gap_ms", dark, 100);
            end
            pat = led;
            ch  = 0;
            for (int j = 0; j < 4; j++) if (pat[j]) ch = j;
            check("play_onehot", $countones(pat), 1);
            check("play_tone", int'(freq), 196 + 96 * ch);
            if (use_model) check("seq_model", ch, int'(m[1:0]));
            if (i < replay) check("replay", ch, seq[i]);
            seq[i] = ch;
            m = lstep(lstep(m));
            on = 0;
            while (led == pat && on < 5000) begin
                cyc(1);
                on++;
            end
            check("on_ms", on, on_exp);
        end
    endtask

    task automatic user_press(input int ch);
        cyc(5);
        btn = 4'(1 << ch);
        cyc(3);
        check("press_led", int'(led), 1 << ch);
        check("press_tone", int'(freq), 196 + 96 * ch);
        cyc(57);
        btn = 4'd0;
    endtask

    initial begin
        logic [15:0] s;
        int pts[6] = '{100, 256, 257, 600, 900, 1100};
        int exp_led[6] = '{1, 1, 2, 4, 8, 1};
        int n;
        int wrong;

        cyc(3);
        check("rst_led", int'(led), 0);
        check("rst_freq", int'(freq), 0);
        check("rst_score", int'(score), 0);
        check("rst_over", int'(game_over), 0);
        check("rst_won", int'(game_won), 0);
        rst_n = 1'b1;

        // IDLE chase: one LED per 256 ms.
        n = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(pts[k] - n);
            n = pts[k];
            check("chase_led", int'(led), exp_led[k]);
        end
        check("idle_freq", int'(freq), 0);
        check("idle_score", int'(score), 0);

        // Start at cycle 2000: 2001 free-running LFSR steps including the press edge.
        cyc(2000 - n);
        btn = 4'b0001;
        s = 16'hACE1;
        repeat (2001) s = lstep(s);
        cyc(1);
        btn = 4'd0;

        // Game 1: three perfect levels, MAX_LEN=3 wins.
        play_pass(1, 500, 300, 1'b1, s, 0);
        check("g1_score0", int'(score), 0);
        cyc(110);
        user_press(seq[0]);
        play_pass(2, 600, 290, 1'b1, s, 1);
        check("g1_score1", int'(score), 1);
        cyc(110);
        for (int i = 0; i < 2; i++) user_press(seq[i]);
        play_pass(3, 600, 280, 1'b1, s, 2);
        check("g1_score2", int'(score), 2);
        cyc(110);
        for (int i = 0; i < 3; i++) user_press(seq[i]);
        cyc(20);
        check("win_flag", int'(game_won), 1);
        check("win_score", int'(score), 3);
        check("win_freq", int'(freq), 0);
        check("win_led", $countones(led), 1);
        check("win_over", int'(game_over), 0);
        cyc(480);
        btn = 4'b0010;
        cyc(10);
        btn = 4'd0;
        cyc(5);
        check("win_early_press", int'(game_won), 1);
        cyc(600);
        btn = 4'b0001;
        cyc(1);
        btn = 4'd0;

        // Game 2: wrong channel at level 2.
        play_pass(1, 500, 300, 1'b0, 16'd0, 0);
        check("g2_won_clr", int'(game_won), 0);
        check("g2_score0", int'(score), 0);
        cyc(110);
        user_press(seq[0]);
        play_pass(2, 600, 290, 1'b0, 16'd0, 1);
        cyc(110);
        wrong = (seq[0] + 1) % 4;
        user_press(wrong);
        cyc(20);
        check("go_flag", int'(game_over), 1);
        check("go_led_on", int'(led), 15);
        check("go_freq", int'(freq), 98);
        check("go_score", int'(score), 1);
        cyc(180);
        check("go_led_off", int'(led), 0);
        cyc(300);
        btn = 4'b0100;
        cyc(10);
        btn = 4'd0;
        cyc(5);
        check("go_early_press", int'(game_over), 1);
        cyc(585);
        check("go_silent", int'(freq), 0);
        check("go_hold", int'(game_over), 1);
        btn = 4'b1000;
        cyc(1);
        btn = 4'd0;

        // Game 3: restart at score 0, then inactivity in USER_WAIT.
        play_pass(1, -1, 300, 1'b0, 16'd0, 0);
        check("g3_score0", int'(score), 0);
        check("g3_over_clr", int'(game_over), 0);
`ifdef SIMON_TIMEOUT_EN
        cyc(140);
        check("to_before", int'(game_over), 0);
        cyc(20);
        check("to_after", int'(game_over), 1);
`else
        btn = 4'(1 << ((seq[0] + 2) % 4));
        cyc(300);
        check("held_entry", int'(led), 0);
        btn = 4'd0;
        cyc(10);
        btn = 4'b0011;
        cyc(100);
        check("multi_bit", int'(led), 0);
        btn = 4'd0;
        cyc(9600);
        check("wait_led", int'(led), 0);
        check("wait_over", int'(game_over), 0);
        check("wait_freq", int'(freq), 0);
        user_press(seq[0]);
        cyc(20);
        check("g3_score1", int'(score), 1);
        check("g3_won", int'(game_won), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
